// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the iterative AES-128 round controller.
package aes_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_BLK_W   = 128;
  localparam int AES_RKIDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host block handshake, key-store lookup and round-datapath signals of the AES round controller.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLK_W-1:0]   in_text;
  logic [AES_RKIDX_W-1:0] rk_idx;
  logic [AES_BLK_W-1:0]   rk;
  logic [AES_BLK_W-1:0]   dp_state;
  logic                   dp_start;
  logic                   dp_last;
  logic [AES_BLK_W-1:0]   dp_result;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLK_W-1:0]   out_text;
  logic                   busy;

  // master: host, key store and round datapath side
  modport master (
    output in_valid, in_text, rk, dp_result, out_ready,
    input  in_ready, rk_idx, dp_state, dp_start, dp_last, out_valid, out_text, busy
  );

  // slave: the round controller itself
  modport slave (
    input  in_valid, in_text, rk, dp_result, out_ready,
    output in_ready, rk_idx, dp_state, dp_start, dp_last, out_valid, out_text, busy
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: owns the block state register and steps an external
// round datapath through NR rounds, selecting round keys by index.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int RND_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  aes_round_ctrl_if.slave bus
);

  localparam logic [AES_RKIDX_W-1:0] LAST_RND  = AES_RKIDX_W'(NR);
  localparam logic [1:0]             WAIT_INIT = (RND_LAT > 0) ? 2'(RND_LAT - 1) : 2'd0;

  aes_state_e             state_q, state_d;
  logic [AES_RKIDX_W-1:0] rnd_q, rnd_d;
  logic [1:0]             wait_q, wait_d;
  logic [AES_BLK_W-1:0]   blk_q, blk_d;
  logic                   capture;
  logic                   in_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      wait_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wait_q  <= wait_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    wait_d  = wait_q;
    blk_d   = blk_q;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        // rk_idx is 0 in IDLE, so rk is the whitening key here
        if (bus.in_valid) begin
          blk_d   = bus.in_text ^ bus.rk;
          rnd_d   = AES_RKIDX_W'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (RND_LAT == 0) begin
          capture = 1'b1;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 2'd0) begin
          capture = 1'b1;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          blk_d   = '0;
          rnd_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      blk_d = bus.dp_result;
      if (rnd_q == LAST_RND) begin
        state_d = DONE;
      end else begin
        rnd_d   = rnd_q + 1'b1;
        state_d = ROUND;
      end
    end

    // abort wins over accept, capture and handshake alike
    if (flush) begin
      state_d = IDLE;
      rnd_d   = '0;
      wait_d  = '0;
      blk_d   = '0;
    end
  end

  always_comb begin
    in_rnd        = (state_q == ROUND) || (state_q == WAIT);
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.dp_start  = (state_q == ROUND);
    bus.dp_last   = in_rnd && (rnd_q == LAST_RND);
    bus.rk_idx    = in_rnd ? rnd_q : '0;
    bus.dp_state  = in_rnd ? blk_q : '0;
    bus.out_valid = (state_q == DONE);
    bus.out_text  = (state_q == DONE) ? blk_q : '0;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption round sequencer. It accepts one plaintext block per transaction and owns the 128-bit state register. It steps an external round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) through NR rounds while selecting round keys from the key store, then presents the ciphertext on a valid/ready output. It sits between the host-side block interface and the round datapath and key-expansion memory.

## Interface
- `NR`, default 10: number of rounds (AES-128).
- `RND_LAT`, default 1: round datapath latency in cycles, 0..3. The registered MixColumns stage gives 1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset. **Asynchronous assert, active-low.**
- `flush` in 1: synchronous abort and zeroize; highest priority after reset.
- `in_valid` in 1: plaintext offered.
- `in_ready` out 1: controller can accept; high only in IDLE.
- `in_text` in 128: plaintext.
- `rk_idx` out 4: round-key index to the key store.
- `rk` in 128: round key for `rk_idx`; combinational from the key store.
- `dp_state` out 128: state presented to the datapath.
- `dp_start` out 1: one-cycle pulse that starts a round.
- `dp_last` out 1: final round; the datapath bypasses MixColumns.
- `dp_result` in 128: datapath output, valid `RND_LAT` cycles after `dp_start`.
- `out_valid` out 1: ciphertext available.
- `out_ready` in 1: consumer accepts.
- `out_text` out 128: ciphertext; forced to 0 whenever `out_valid`=0.
- `busy` out 1: high in ROUND, WAIT or DONE.

## Operation
- **States and transitions:**
  - IDLE → ROUND on accept.
  - ROUND → WAIT if `RND_LAT`>0.
  - ROUND → next ROUND or DONE if `RND_LAT`=0.
  - WAIT → next ROUND or DONE when the wait count expires.
  - DONE → IDLE on `out_valid`&&`out_ready`.
- **Accept** (`in_valid`&&`in_ready` in IDLE): `rk_idx`=0 in IDLE, so the state register loads `in_text ^ rk`. The round counter r is set to 1.
- **ROUND:** `dp_start`=1, `dp_state`=state register, `rk_idx`=r, `dp_last`=(r==NR).
- **Stability:** `rk_idx`, `dp_state` and `dp_last` hold stable from the ROUND cycle through the capture cycle.
- **WAIT:** a wait counter loads `RND_LAT`-1 and decrements.
- **Capture:** the state register loads `dp_result` at the end of the last WAIT cycle, or at the end of ROUND when `RND_LAT`=0.
- **Round advance:** after capture, r<NR gives r+1 and ROUND. r==NR goes to DONE. r never exceeds NR.
- **DONE:** `out_valid`=1 and `out_text`=state register, both held until the handshake. `in_valid` is ignored. On handshake the state register is zeroed and the FSM enters IDLE.
- **No overlap:** a new block can be accepted no earlier than the cycle after the DONE handshake.
- **flush:** in any state, next cycle is IDLE, state register = 0 and r = 0. No `out_valid` is produced. A flush in DONE cancels the pending result. Flush wins over a simultaneous accept or handshake.
- **Datapath outputs outside ROUND/WAIT:** `dp_start`=0, `dp_last`=0, `dp_state`=0 (zeroization).

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_text`=0, `dp_start`=0, `dp_last`=0, `rk_idx`=0, `dp_state`=0, `busy`=0. State is IDLE, r=0, state register 0.
- **Reset mid-operation:** immediate return to the reset values; there is no partial output.
- **Latency:** accept at edge E0 (end of cycle 0). `out_valid` rises in cycle NR·(1+`RND_LAT`)+1: cycle 21 at the defaults, cycle 11 with `RND_LAT`=0.
- **Throughput:** one block per NR·(1+`RND_LAT`)+2 cycles with `out_ready` tied high.
- **Registered outputs:** `in_ready`, `busy`, `dp_*` and `out_*` decode from registered state only. There are no combinational paths from `in_valid`/`out_ready` to outputs.

## Structure
- **Shared package `aes_pkg`:**
  - state enum (IDLE, ROUND, WAIT, DONE);
  - `AES_NR`=10;
  - `AES_BLK_W`=128;
  - `AES_RKIDX_W`=4.
- **Single module, no sub-module.** The round and wait counters are inline. The round datapath and key store are external.

## Test plan
- **FIPS-197 vector.** Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, with the bench datapath model at `RND_LAT`=1. Required: `out_text`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` in cycle 21, `rk_idx` sequence 0,1..10, `dp_last` only in round 10.
- **Output backpressure.** Stimulus: `out_ready` low for 5 cycles in DONE, `in_valid` high. Required: `out_text` stable, `in_ready`=0, no second accept. Accept occurs the cycle after the handshake.
- **Flush during round 5 WAIT.** Required: IDLE next cycle, `in_ready`=1, `dp_state`=0, no `out_valid`. A following FIPS vector still gives the correct result.
- **Async reset mid-op.** Stimulus: `rst_n` low in round 7. Required: all outputs at reset values while `rst_n`=0. Clean operation after release.
- **Latency parameter.** Stimulus: `RND_LAT`=0 and `RND_LAT`=2. Required: `out_valid` in cycle 11 and cycle 31, same ciphertext.
- **Back-to-back blocks.** Stimulus: `out_ready`=1, 3 blocks. Required: 22-cycle spacing between `out_valid` pulses and correct ciphertexts.
